// File: rtl/leg_cache_pkg.sv
// Shared types for the LEG data cache controller.
// FSM state encoding and read-data mux selects.
package leg_cache_pkg;

  typedef enum logic [2:0] {
    S_READY,
    S_WRITEBACK,
    S_MEMREAD,
    S_FILLDONE,
    S_UNC_READ,
    S_UNC_WRITE,
    S_WAIT
  } cache_state_t;

  localparam logic [1:0] RDSEL_CACHE = 2'd0;
  localparam logic [1:0] RDSEL_CRIT  = 2'd1;
  localparam logic [1:0] RDSEL_BUS   = 2'd2;

endpackage

// File: rtl/data_nway_writeback_cache_controller_way_select.sv
// Way selection: hit way, else first invalid way,
// else the external victim choice. Lowest index wins.
module cache_way_select #(
  parameter int NWAYS   = 4,
  parameter int TAGBITS = 14,
  localparam int WYB    = $clog2(NWAYS)
) (
  input  logic                     enable,
  input  logic [NWAYS-1:0]         valid,
  input  logic [NWAYS-1:0]         dirty,
  input  logic [NWAYS*TAGBITS-1:0] way_tags,
  input  logic [TAGBITS-1:0]       tag,
  input  logic [WYB-1:0]           victim_way,
  output logic                     hit,
  output logic [WYB-1:0]           sel_way,
  output logic [TAGBITS-1:0]       cached_tag,
  output logic                     vdirty
);

  logic           hit_any;
  logic           inv_any;
  logic [WYB-1:0] hit_way;
  logic [WYB-1:0] inv_way;

  // Descending scan so the lowest matching index is left last.
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (valid[w] &&
          way_tags[w*TAGBITS +: TAGBITS] == tag) begin
        hit_any = 1'b1;
        hit_way = WYB'(w);
      end
      if (!valid[w]) begin
        inv_any = 1'b1;
        inv_way = WYB'(w);
      end
    end
  end

  assign hit = hit_any & enable;

  always_comb begin
    if (hit)          sel_way = hit_way;
    else if (inv_any) sel_way = inv_way;
    else              sel_way = victim_way;
  end

  assign cached_tag = way_tags[sel_way*TAGBITS +: TAGBITS];
  assign vdirty     = dirty[sel_way];

endmodule

// File: rtl/data_nway_writeback_cache_controller.sv
// Write-back, write-allocate N-way data cache controller:
// hit/miss, writeback, line fill and uncached access.
module data_nway_writeback_cache_controller
  import leg_cache_pkg::*;
#(
  parameter int NWAYS     = 4,
  parameter int BLOCKSIZE = 4,
  parameter int TAGBITS   = 14,
  localparam int WOB      = $clog2(BLOCKSIZE),
  localparam int WYB      = $clog2(NWAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     MemWriteM,
  input  logic                     MemtoRegM,
  input  logic                     IStall,
  input  logic                     BusReady,
  input  logic [NWAYS-1:0]         Valid,
  input  logic [NWAYS-1:0]         Dirty,
  input  logic [NWAYS*TAGBITS-1:0] WayTags,
  input  logic [TAGBITS-1:0]       Tag,
  input  logic [WYB-1:0]           VictimWay,
  input  logic [WOB-1:0]           WordOffset,
  input  logic [3:0]               ByteMask,
  output logic                     Stall,
  output logic                     HRequestM,
  output logic                     HWriteM,
  output logic                     UseCacheA,
  output logic                     Hit,
  output logic [WYB-1:0]           SelWay,
  output logic [NWAYS-1:0]         WayWE,
  output logic                     CWE,
  output logic                     BlockWE,
  output logic                     UseWD,
  output logic                     DirtyIn,
  output logic                     LRUUpdate,
  output logic [TAGBITS-1:0]       CachedTag,
  output logic [3:0]               ActiveByteMask,
  output logic [WOB-1:0]           Counter,
  output logic [WOB-1:0]           NewWordOffset,
  output logic [1:0]               RDSel
);

  cache_state_t   state_q, state_d;
  logic [WOB-1:0] cnt_q, cnt_d;
  logic           unc_q, unc_d;
  logic           vdirty;
  logic           mem_op;
  logic           last_beat;
  logic           we_en;
  logic           bursting;

  cache_way_select #(
    .NWAYS   (NWAYS),
    .TAGBITS (TAGBITS)
  ) u_way_sel (
    .enable     (enable),
    .valid      (Valid),
    .dirty      (Dirty),
    .way_tags   (WayTags),
    .tag        (Tag),
    .victim_way (VictimWay),
    .hit        (Hit),
    .sel_way    (SelWay),
    .cached_tag (CachedTag),
    .vdirty     (vdirty)
  );

  assign mem_op    = MemWriteM | MemtoRegM;
  assign last_beat = (cnt_q == WOB'(BLOCKSIZE - 1));
  assign bursting  = (state_q == S_WRITEBACK) ||
                     (state_q == S_MEMREAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_READY;
      cnt_q   <= '0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unc_q   <= unc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    unc_d     = unc_q;
    Stall     = 1'b0;
    HWriteM   = 1'b0;
    UseCacheA = 1'b0;
    BlockWE   = 1'b0;
    UseWD     = 1'b0;
    DirtyIn   = 1'b0;
    LRUUpdate = 1'b0;
    we_en     = 1'b0;
    RDSel     = RDSEL_CACHE;
    unique case (state_q)
      S_READY: begin
        cnt_d = '0;
        if (mem_op && Hit) begin
          LRUUpdate = 1'b1;
          if (MemWriteM) begin
            we_en   = 1'b1;
            UseWD   = 1'b1;
            DirtyIn = 1'b1;
          end
        end else if (mem_op) begin
          Stall = 1'b1;
          unc_d = ~enable;
          if (!enable)
            state_d = MemWriteM ? S_UNC_WRITE : S_UNC_READ;
          else if (vdirty)
            state_d = S_WRITEBACK;
          else
            state_d = S_MEMREAD;
        end
      end
      S_WRITEBACK: begin
        Stall     = 1'b1;
        HWriteM   = 1'b1;
        UseCacheA = 1'b1;
        if (BusReady) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_MEMREAD;
          end
        end
      end
      S_MEMREAD: begin
        Stall   = 1'b1;
        BlockWE = 1'b1;
        if (BusReady) begin
          we_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = S_FILLDONE;
        end
      end
      S_FILLDONE: begin
        LRUUpdate = 1'b1;
        cnt_d     = '0;
        RDSel     = unc_q ? RDSEL_BUS : RDSEL_CRIT;
        // Pending store lands only once the line is resident.
        if (MemWriteM && !unc_q) begin
          we_en   = 1'b1;
          UseWD   = 1'b1;
          DirtyIn = 1'b1;
        end
        state_d = IStall ? S_WAIT : S_READY;
      end
      S_UNC_READ: begin
        Stall = 1'b1;
        if (BusReady) state_d = S_FILLDONE;
      end
      S_UNC_WRITE: begin
        Stall   = 1'b1;
        HWriteM = 1'b1;
        if (BusReady) state_d = S_FILLDONE;
      end
      S_WAIT: begin
        RDSel = unc_q ? RDSEL_BUS : RDSEL_CRIT;
        if (!IStall) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  assign HRequestM      = Stall;
  assign WayWE          = we_en ?
    ({{(NWAYS-1){1'b0}}, 1'b1} << SelWay) : '0;
  assign CWE            = |WayWE;
  assign ActiveByteMask = UseWD ? ByteMask : 4'hF;
  assign Counter        = enable ? cnt_q : WordOffset;
  assign NewWordOffset  = bursting ? Counter : WordOffset;

endmodule
